// File: rtl/ftdi_rx_prefetch.sv
// Receive prefetch pump for the FTDI read engine: keeps one byte read in flight while buffer space
// remains, and presents the buffered bytes as a first-word-fall-through valid/ready stream.
module ftdi_rx_prefetch #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   output logic          oACT_RD_n,
   input  logic          iREADY_RD_n,
   input  logic          iDONE_RD_n,
   input  logic [7:0]    iRD_DATA,
   input  logic          iENABLE,
   input  logic          iFLUSH,
   output logic [7:0]    oDATA,
   output logic          oVALID,
   input  logic          iREADY,
   output logic [AW:0]   oLEVEL,
   output logic [31:0]   oBYTE_COUNT,
   output logic          oPROTO_ERR
);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_t;

   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   state_t        state;
   state_t        state_next;
   logic          discard_pending;
   logic          discard_next;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [7:0]    mem [DEPTH];
   logic          done;
   logic          push;
   logic          pop;
   logic          can_issue;

   assign done      = ~iDONE_RD_n;
   assign oVALID    = (oLEVEL != '0);
   assign pop       = oVALID & iREADY;
   assign oDATA     = mem[rd_ptr];
   assign can_issue = iENABLE & ~iREADY_RD_n & (oLEVEL < FULL_LEVEL) & ~iFLUSH;

   // A flush seen while a read is in flight must also kill the byte it eventually returns,
   // including when the flush lands on the very cycle the byte arrives.
   always_comb begin
      state_next   = state;
      discard_next = discard_pending;
      oACT_RD_n    = 1'b1;
      push         = 1'b0;
      case (state)
         IDLE: begin
            discard_next = 1'b0;
            if (can_issue) state_next = ISSUE;
         end
         ISSUE: begin
            oACT_RD_n  = 1'b0;
            state_next = WAIT;
            if (iFLUSH) discard_next = 1'b1;
         end
         WAIT: begin
            if (iFLUSH) discard_next = 1'b1;
            if (done) begin
               push         = ~(discard_pending | iFLUSH);
               discard_next = 1'b0;
               state_next   = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= IDLE;
         discard_pending <= 1'b0;
      end else begin
         state           <= state_next;
         discard_pending <= discard_next;
      end
   end

   // Buffer storage, pointers and the level counter; flush wins over any same-cycle pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         oLEVEL      <= '0;
         oBYTE_COUNT <= '0;
         oPROTO_ERR  <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= iRD_DATA;
            wr_ptr      <= wr_ptr + AW'(1);
            oBYTE_COUNT <= oBYTE_COUNT + 32'd1;
         end
         if (iFLUSH) begin
            rd_ptr <= wr_ptr;
            oLEVEL <= '0;
         end else begin
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) oLEVEL <= oLEVEL + (AW+1)'(1);
            else if (!push && pop) oLEVEL <= oLEVEL - (AW+1)'(1);
         end
         if (done && state != WAIT) oPROTO_ERR <= 1'b1;
      end
   end

endmodule
